// File: rtl/cache_req_issuer_pkg.sv
// Shared cache interface types plus the request issuer's local types.
package cache_req_issuer_pkg;

  localparam int CACHE_ADDR_W = 27;

  typedef struct packed {
    logic [CACHE_ADDR_W-1:0] addr;
    logic [31:0]             data;
    logic                    rw;
    logic                    valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef enum logic [1:0] {IDLE, REQ, GAP} issuer_state_t;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_entry_t;

  // Word accesses only: any low address bit set means the request cannot be issued.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/cache_req_issuer_req_fifo.sv
// In-order request queue. A push while full is dropped even if a pop happens
// in the same cycle, so in_ready can be derived purely from the registered count.
module cache_req_issuer_req_fifo #(
  parameter int DEPTH = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cache_req_issuer.sv
// Queues pipeline word load/stores and issues them one at a time to L1_cache,
// returning one in-order response per request with misalign/hang diagnostics.
module cache_req_issuer
  import cache_req_issuer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic           sys_clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_rw,
  input  logic [31:0]    in_addr,
  input  logic [31:0]    in_wdata,
  output cpu_req_type    cpu_to_cache_request,
  input  cpu_result_type cpu_res,
  output logic           rsp_valid,
  output logic           rsp_rw,
  output logic [31:0]    rsp_data,
  output logic           rsp_err,
  output logic           busy,
  output logic           hang
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  issuer_state_t    state;
  req_entry_t       push_entry;
  req_entry_t       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             pop;
  logic [TMR_W-1:0] timer;

  assign push_entry = '{rw: in_rw, addr: in_addr, wdata: in_wdata};
  assign in_ready   = !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign busy       = (fifo_count != '0) || (state != IDLE);

  cache_req_issuer_req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (req_entry_t)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Issue FSM: pops the head in IDLE, holds the request in REQ until ready,
  // then forces one idle GAP cycle. Timer counts down from TIMEOUT while in REQ.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state                <= IDLE;
      cpu_to_cache_request <= '0;
      rsp_valid            <= 1'b0;
      rsp_rw               <= 1'b0;
      rsp_data             <= '0;
      rsp_err              <= 1'b0;
      hang                 <= 1'b0;
      timer                <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (is_misaligned(head.addr[1:0])) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rw    <= head.rw;
              rsp_data  <= '0;
            end else begin
              cpu_to_cache_request.addr  <= head.addr[28:2];
              cpu_to_cache_request.data  <= head.wdata;
              cpu_to_cache_request.rw    <= head.rw;
              cpu_to_cache_request.valid <= 1'b1;
              timer                      <= TMR_W'(TIMEOUT);
              state                      <= REQ;
            end
          end
        end
        REQ: begin
          if (cpu_res.ready) begin
            cpu_to_cache_request.valid <= 1'b0;
            rsp_valid                  <= 1'b1;
            rsp_err                    <= 1'b0;
            rsp_rw                     <= cpu_to_cache_request.rw;
            rsp_data                   <= cpu_to_cache_request.rw ? 32'd0 : cpu_res.data;
            state                      <= GAP;
          end else if (timer != '0) begin
            timer <= timer - 1'b1;
            if (timer == TMR_W'(1)) hang <= 1'b1;
          end
        end
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_issuer.sv
// Directed bench for cache_req_issuer with a small behavioural L1 responder.
module tb_cache_req_issuer;
  import cache_req_issuer_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;

  logic           sys_clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_rw = 1'b0;
  logic [31:0]    in_addr = '0;
  logic [31:0]    in_wdata = '0;
  logic           in_ready;
  cpu_req_type    req;
  cpu_result_type res;
  logic           rsp_valid, rsp_rw, rsp_err, busy, hang;
  logic [31:0]    rsp_data;

  always #5 sys_clk = ~sys_clk;

  cache_req_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk              (sys_clk),
    .rst                  (rst),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_rw                (in_rw),
    .in_addr              (in_addr),
    .in_wdata             (in_wdata),
    .cpu_to_cache_request (req),
    .cpu_res              (res),
    .rsp_valid            (rsp_valid),
    .rsp_rw               (rsp_rw),
    .rsp_data             (rsp_data),
    .rsp_err              (rsp_err),
    .busy                 (busy),
    .hang                 (hang)
  );

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------- L1 responder model ----------------
  logic [31:0] mem [logic [26:0]];
  bit          cache_stall = 1'b0;
  bit          spur = 1'b0;
  int          cache_delay = 1;
  int          vcnt = 0;
  logic        res_ready = 1'b0;
  logic [31:0] res_data = '0;
  int          ready_cyc_q[$];

  assign res = '{data: res_data, ready: res_ready};

  function automatic logic [31:0] model_rd(input logic [26:0] a);
    if (mem.exists(a)) return mem[a];
    return {5'd0, a} ^ 32'h5A00_0000;
  endfunction

  always @(negedge sys_clk) begin
    res_ready = 1'b0;
    res_data  = '0;
    if (rst) begin
      vcnt = 0;
    end else if (req.valid) begin
      vcnt = vcnt + 1;
      if (!cache_stall && vcnt >= cache_delay) begin
        res_ready = 1'b1;
        vcnt      = 0;
        ready_cyc_q.push_back(cyc);
        if (req.rw) begin
          mem[req.addr] = req.data;
          res_data      = 32'hFFFF_0000;
        end else begin
          res_data = model_rd(req.addr);
        end
      end
    end else begin
      vcnt = 0;
      if (spur) begin
        res_ready = 1'b1;
        res_data  = 32'hBAD0_BAD0;
      end
    end
  end

  // ---------------- monitor ----------------
  typedef struct packed {logic [26:0] addr; logic [31:0] data; logic rw; int c;} req_rec_t;
  typedef struct packed {logic rw; logic err; logic [31:0] data; int c;} rsp_rec_t;
  req_rec_t req_q[$];
  rsp_rec_t rsp_q[$];
  int       gap_q[$];
  bit       prev_v = 1'b0;
  int       low_run = 0;

  always @(negedge sys_clk) begin
    if (req.valid && !prev_v) begin
      req_q.push_back('{req.addr, req.data, req.rw, cyc});
      if (req_q.size() > 1) gap_q.push_back(low_run);
    end
    low_run = req.valid ? 0 : low_run + 1;
    prev_v  = req.valid;
    if (rsp_valid) rsp_q.push_back('{rsp_rw, rsp_err, rsp_data, cyc});
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    req_q.delete();
    rsp_q.delete();
    gap_q.delete();
    ready_cyc_q.delete();
  endtask

  task automatic push(input logic rw, input logic [31:0] a, input logic [31:0] d,
                      output bit acc, output int pc);
    @(negedge sys_clk);
    in_valid = 1'b1;
    in_rw    = rw;
    in_addr  = a;
    in_wdata = d;
    acc      = in_ready;
    pc       = cyc;
    @(negedge sys_clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (busy && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check({tag, "_drain"}, 32'(busy), 32'd0);
    repeat (3) @(negedge sys_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int pc, pc0, h, n_acc;
    bit seen;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_valid",     32'(req.valid), 32'd0);
    check("rst_addr",      32'(req.addr),  32'd0);
    check("rst_data",      req.data,       32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  rsp_data,       32'd0);
    check("rst_hang",      32'(hang),      32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;

    // Write then read same word, cache ready on 5th REQ cycle
    cache_delay = 5;
    clear_logs();
    push(1'b1, 32'h0AAA_AAA8, 32'h3333_3333, acc, pc0);
    push(1'b0, 32'h0AAA_AAA8, 32'h0, acc, pc);
    wait_idle(100, "t1");
    check("t1_req_n", 32'(req_q.size()), 32'd2);
    if (req_q.size() == 2) begin
      check("t1_addr0", 32'(req_q[0].addr), 32'h02AA_AAAA);
      check("t1_rw0",   32'(req_q[0].rw),   32'd1);
      check("t1_wd0",   req_q[0].data,      32'h3333_3333);
      check("t1_addr1", 32'(req_q[1].addr), 32'h02AA_AAAA);
      check("t1_rw1",   32'(req_q[1].rw),   32'd0);
      check("t1_issue_lat", 32'(req_q[0].c - pc0), 32'd2);
    end
    // GAP cycle plus the IDLE pop cycle separate the two requests
    check("t1_gap_n", 32'(gap_q.size()), 32'd1);
    if (gap_q.size() == 1) check("t1_gap_len", 32'(gap_q[0]), 32'd2);
    check("t1_rsp_n", 32'(rsp_q.size()), 32'd2);
    if (rsp_q.size() == 2 && ready_cyc_q.size() == 2) begin
      check("t1_rsp0_rw",   32'(rsp_q[0].rw),  32'd1);
      check("t1_rsp0_data", rsp_q[0].data,     32'd0);
      check("t1_rsp0_err",  32'(rsp_q[0].err), 32'd0);
      check("t1_rsp1_rw",   32'(rsp_q[1].rw),  32'd0);
      check("t1_rsp1_data", rsp_q[1].data,     32'h3333_3333);
      check("t1_rsp_lat",   32'(rsp_q[0].c - ready_cyc_q[0]), 32'd1);
    end

    // Misaligned entries between aligned reads; upper address bits ignored
    cache_delay = 2;
    clear_logs();
    push(1'b0, 32'hE000_0100, 32'h0, acc, pc);
    push(1'b0, 32'h0000_0006, 32'h0, acc, pc);
    push(1'b0, 32'h0000_0200, 32'h0, acc, pc);
    push(1'b1, 32'h0000_000B, 32'h1234_5678, acc, pc);
    wait_idle(100, "t2");
    check("t2_req_n", 32'(req_q.size()), 32'd2);
    if (req_q.size() == 2) begin
      check("t2_addr0", 32'(req_q[0].addr), 32'h0000_0040);
      check("t2_addr1", 32'(req_q[1].addr), 32'h0000_0080);
    end
    check("t2_rsp_n", 32'(rsp_q.size()), 32'd4);
    if (rsp_q.size() == 4) begin
      check("t2_rsp0_err",  32'(rsp_q[0].err), 32'd0);
      check("t2_rsp0_data", rsp_q[0].data,     32'h5A00_0040);
      check("t2_rsp1_err",  32'(rsp_q[1].err), 32'd1);
      check("t2_rsp1_data", rsp_q[1].data,     32'd0);
      check("t2_rsp1_rw",   32'(rsp_q[1].rw),  32'd0);
      check("t2_rsp2_err",  32'(rsp_q[2].err), 32'd0);
      check("t2_rsp2_data", rsp_q[2].data,     32'h5A00_0080);
      check("t2_rsp3_err",  32'(rsp_q[3].err), 32'd1);
      check("t2_rsp3_rw",   32'(rsp_q[3].rw),  32'd1);
      check("t2_rsp3_data", rsp_q[3].data,     32'd0);
    end

    // Fill: a stalled blocker sits in REQ, then DEPTH+1 pushes
    cache_stall = 1'b1;
    clear_logs();
    push(1'b0, 32'h0000_1000, 32'h0, acc, pc);
    n_acc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      push(1'b0, 32'h0000_2000 + 32'(4 * i), 32'h0, acc, pc);
      if (acc) n_acc++;
    end
    check("t3_accepted", 32'(n_acc), 32'(DEPTH));
    check("t3_in_ready_full", 32'(in_ready), 32'd0);
    push(1'b0, 32'h0000_2000 + 32'(4 * DEPTH), 32'h0, acc, pc);
    check("t3_extra_refused", 32'(acc), 32'd0);
    cache_stall = 1'b0;
    cache_delay = 1;
    wait_idle(200, "t3");
    check("t3_req_n", 32'(req_q.size()), 32'(DEPTH + 1));
    if (req_q.size() == DEPTH + 1) begin
      check("t3_blocker", 32'(req_q[0].addr), 32'h0000_0400);
      for (int i = 0; i < DEPTH; i++)
        check($sformatf("t3_order%0d", i), 32'(req_q[i + 1].addr), 32'h0000_0800 + 32'(i));
    end
    check("t3_rsp_n", 32'(rsp_q.size()), 32'(DEPTH + 1));

    // Hang: cache never answers
    cache_stall = 1'b1;
    clear_logs();
    push(1'b0, 32'h0000_0400, 32'h0, acc, pc);
    seen = 1'b0;
    h = 0;
    for (int i = 0; i < TIMEOUT + 20 && !seen; i++) begin
      @(negedge sys_clk);
      if (hang) begin
        seen = 1'b1;
        h = cyc;
      end
    end
    check("t4_hang_seen", 32'(seen), 32'd1);
    if (req_q.size() == 1) check("t4_hang_lat", 32'(h - req_q[0].c), 32'(TIMEOUT));
    check("t4_valid", 32'(req.valid), 32'd1);
    check("t4_addr",  32'(req.addr),  32'h0000_0100);
    repeat (5) @(negedge sys_clk);
    check("t4_valid_hold", 32'(req.valid), 32'd1);
    check("t4_addr_hold",  32'(req.addr),  32'h0000_0100);
    check("t4_hang_sticky", 32'(hang), 32'd1);
    check("t4_no_rsp", 32'(rsp_q.size()), 32'd0);

    // Reset mid-REQ with two entries queued
    push(1'b0, 32'h0000_0500, 32'h0, acc, pc);
    push(1'b0, 32'h0000_0600, 32'h0, acc, pc);
    clear_logs();
    @(negedge sys_clk);
    rst = 1'b1;
    cache_stall = 1'b0;
    cache_delay = 2;
    @(negedge sys_clk);
    rst = 1'b0;
    check("t5_valid", 32'(req.valid), 32'd0);
    check("t5_busy",  32'(busy),      32'd0);
    check("t5_hang",  32'(hang),      32'd0);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (5) @(negedge sys_clk);
    check("t5_no_rsp", 32'(rsp_q.size()), 32'd0);
    check("t5_no_req", 32'(req_q.size()), 32'd0);
    push(1'b1, 32'h0000_0700, 32'hCAFE_F00D, acc, pc);
    wait_idle(100, "t5");
    check("t5_req_n", 32'(req_q.size()), 32'd1);
    if (req_q.size() == 1) check("t5_addr", 32'(req_q[0].addr), 32'h0000_01C0);
    check("t5_rsp_n", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() == 1) check("t5_rsp_rw", 32'(rsp_q[0].rw), 32'd1);

    // Spurious ready in IDLE and GAP
    clear_logs();
    spur = 1'b1;
    cache_delay = 3;
    repeat (4) @(negedge sys_clk);
    check("t6_idle_no_rsp", 32'(rsp_q.size()), 32'd0);
    check("t6_idle_busy",   32'(busy),      32'd0);
    check("t6_idle_valid",  32'(req.valid), 32'd0);
    push(1'b0, 32'h0000_0800, 32'h0, acc, pc);
    push(1'b0, 32'h0000_0804, 32'h0, acc, pc);
    wait_idle(100, "t6");
    spur = 1'b0;
    check("t6_req_n", 32'(req_q.size()), 32'd2);
    check("t6_rsp_n", 32'(rsp_q.size()), 32'd2);
    if (rsp_q.size() == 2) begin
      check("t6_rsp0_data", rsp_q[0].data, 32'h5A00_0200);
      check("t6_rsp1_data", rsp_q[1].data, 32'h5A00_0201);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
